// File: rtl/bulb_cmd_scheduler.sv
// bulb_cmd_scheduler: round-robin command arbiter for one smart bulb link, with brightness fading.
//   clk, rst_n        clock; asynchronous active-low reset
//   req_valid[i]      requester i has a command pending
//   req_ready[i]      one-hot grant, only ever raised in IDLE
//   req_on/req_bright/req_color   per-requester payload, slices of width 1 / BR_W / 2
//   on_off, brightness, color     current bulb state driven to the link
//   busy              a command is being carried out (FADE)
//   grant_id          index of the last accepted requester
module bulb_cmd_scheduler #(
    parameter int NREQ        = 2,
    parameter int BR_W        = 4,
    parameter int STEP_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_on,
    input  logic [NREQ*BR_W-1:0]      req_bright,
    input  logic [NREQ*2-1:0]         req_color,
    output logic                      on_off,
    output logic [BR_W-1:0]           brightness,
    output logic [1:0]                color,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
    typedef enum logic {IDLE, FADE} state_t;
    state_t          state, state_n;
    logic [PW-1:0]   ptr, sel;
    logic [PW:0]     idx;
    logic            found, xfer, at_target, step, cmd_on;
    logic [CW-1:0]   cnt;
    logic [BR_W-1:0] target;
    always_comb begin
        req_ready = '0;
        sel       = '0;
        found     = 1'b0;
        idx       = '0;
        // idx is one bit wider than ptr so ptr+k cannot overflow before the mod-NREQ fold
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
            if (!found && req_valid[idx[PW-1:0]]) begin
                found = 1'b1;
                sel   = idx[PW-1:0];
            end
        end
        // rst_n gating keeps ready low while reset is asserted, even though state already reads IDLE
        if (state == IDLE && rst_n && found) req_ready[sel] = 1'b1;
        xfer      = |req_ready;
        at_target = brightness == target;
        step      = cnt == CW'(STEP_CYCLES - 1);
        busy      = state == FADE;
        state_n   = (state == IDLE) ? (xfer ? FADE : IDLE) : (at_target ? IDLE : FADE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            target     <= '0;
            cmd_on     <= 1'b0;
            on_off     <= 1'b0;
            brightness <= '0;
            color      <= '0;
            grant_id   <= '0;
        end else begin
            state <= state_n;
            if (xfer) begin
                cmd_on   <= req_on[sel];
                target   <= req_on[sel] ? req_bright[sel*BR_W +: BR_W] : '0;
                grant_id <= sel;
                ptr      <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
                cnt      <= '0;
                if (req_on[sel]) begin
                    on_off <= 1'b1;
                    color  <= req_color[sel*2 +: 2];
                end
            end else if (state == FADE) begin
                // an off command keeps the bulb powered through the ramp-down and drops it on exit
                if (at_target) begin
                    if (!cmd_on) on_off <= 1'b0;
                end else if (step) begin
                    cnt        <= '0;
                    brightness <= (brightness < target) ? brightness + 1'b1 : brightness - 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule
